// File: rtl/glitcbus_master.sv
`default_nettype none
// ============================================================================
// Module   : glitcbus_master
// Purpose  : Initiator end of the GLITCBUS byte-wide link. Takes one 32-bit
//            register read or write command at a time and frames it onto
//            GSEL_B / GRDWR_B / GAD, capturing read data from the slave.
//            Frame: ADDR_HI, ADDR_LO, then 4 write beats, or TURNAROUND
//            released cycles followed by 4 read samples; then an idle gap.
// Ports    : clk_i, rst_n_i (sync, active low)
//            cmd_valid_i/cmd_ready_o, cmd_wr_i, cmd_addr_i[15:0],
//            cmd_dat_i[31:0]                    - command side
//            done_o, rsp_dat_o[31:0]            - completion / read data
//            gsel_b_o, grdwr_b_o, gad_o[7:0], gad_oe_o, gad_i[7:0] - bus
//            debug_o[70:0]                      - only with
//                                                 GLITCBUS_MASTER_DEBUG_EN
// Params   : TURNAROUND (1..7), IDLE_CYCLES (1..7)
// Revision : 1.0 - initial release
// ============================================================================
module glitcbus_master #(
  parameter int TURNAROUND  = 2,
  parameter int IDLE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_wr_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        done_o,
  output logic [31:0] rsp_dat_o,
  output logic        gsel_b_o,
  output logic        grdwr_b_o,
  output logic [7:0]  gad_o,
  output logic        gad_oe_o,
  input  logic [7:0]  gad_i
`ifdef GLITCBUS_MASTER_DEBUG_EN
  ,
  output logic [70:0] debug_o
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ADDR_HI = 3'd1,
    ST_ADDR_LO = 3'd2,
    ST_WDATA   = 3'd3,
    ST_TURN    = 3'd4,
    ST_RDATA   = 3'd5,
    ST_GAP     = 3'd6
  } state_t;

  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);
  localparam logic [2:0] GAP_LAST  = 3'(IDLE_CYCLES - 1);

  state_t      state, state_nx;
  logic [1:0]  beat, beat_nx;
  logic [2:0]  cnt, cnt_nx;
  logic        lat_wr;
  logic [15:0] lat_addr;
  logic [31:0] lat_dat;
  logic [23:0] rd_shift, rd_shift_nx;
  logic        accept;
  logic        gsel_nx, grdwr_nx, oe_nx, ready_nx, done_nx;
  logic [7:0]  gad_nx;
  logic [31:0] rsp_nx;

  function automatic logic [7:0] wbyte(input logic [31:0] d, input logic [1:0] i);
    case (i)
      2'd0:    return d[31:24];
      2'd1:    return d[23:16];
      2'd2:    return d[15:8];
      default: return d[7:0];
    endcase
  endfunction

  assign accept = cmd_valid_i & cmd_ready_o;

  // All bus outputs are registered from next-state values so the bus shows
  // the new phase right after the edge that enters it.
  always_comb begin
    state_nx    = state;
    beat_nx     = beat;
    cnt_nx      = cnt;
    rd_shift_nx = rd_shift;
    rsp_nx      = rsp_dat_o;
    gsel_nx     = 1'b1;
    grdwr_nx    = 1'b1;
    oe_nx       = 1'b0;
    gad_nx      = 8'h00;
    ready_nx    = 1'b0;
    done_nx     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nx = ST_ADDR_HI;
          gsel_nx  = 1'b0;
          grdwr_nx = ~cmd_wr_i;
          oe_nx    = 1'b1;
          gad_nx   = cmd_addr_i[15:8];
        end else begin
          ready_nx = 1'b1;
        end
      end
      ST_ADDR_HI: begin
        state_nx = ST_ADDR_LO;
        gsel_nx  = 1'b0;
        grdwr_nx = ~lat_wr;
        oe_nx    = 1'b1;
        gad_nx   = lat_addr[7:0];
      end
      ST_ADDR_LO: begin
        gsel_nx  = 1'b0;
        grdwr_nx = ~lat_wr;
        beat_nx  = 2'd0;
        cnt_nx   = 3'd0;
        if (lat_wr) begin
          state_nx = ST_WDATA;
          oe_nx    = 1'b1;
          gad_nx   = wbyte(lat_dat, 2'd0);
        end else begin
          state_nx = ST_TURN;
        end
      end
      ST_WDATA: begin
        if (beat == 2'd3) begin
          state_nx = ST_GAP;
          beat_nx  = 2'd0;
          cnt_nx   = 3'd0;
          done_nx  = 1'b1;
        end else begin
          beat_nx  = beat + 2'd1;
          gsel_nx  = 1'b0;
          grdwr_nx = 1'b0;
          oe_nx    = 1'b1;
          gad_nx   = wbyte(lat_dat, beat + 2'd1);
        end
      end
      ST_TURN: begin
        gsel_nx = 1'b0;
        // The edge that closes the last turnaround cycle takes the first byte.
        if (cnt == TURN_LAST) begin
          state_nx    = ST_RDATA;
          cnt_nx      = 3'd0;
          beat_nx     = 2'd1;
          rd_shift_nx = {rd_shift[15:0], gad_i};
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      ST_RDATA: begin
        if (beat == 2'd3) begin
          state_nx = ST_GAP;
          beat_nx  = 2'd0;
          cnt_nx   = 3'd0;
          done_nx  = 1'b1;
          rsp_nx   = {rd_shift, gad_i};
        end else begin
          gsel_nx     = 1'b0;
          beat_nx     = beat + 2'd1;
          rd_shift_nx = {rd_shift[15:0], gad_i};
        end
      end
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = ST_IDLE;
          cnt_nx   = 3'd0;
          ready_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 3'd1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      beat        <= 2'd0;
      cnt         <= 3'd0;
      lat_wr      <= 1'b0;
      lat_addr    <= 16'h0000;
      lat_dat     <= 32'h0;
      rd_shift    <= 24'h0;
      rsp_dat_o   <= 32'h0;
      gsel_b_o    <= 1'b1;
      grdwr_b_o   <= 1'b1;
      gad_oe_o    <= 1'b0;
      gad_o       <= 8'h00;
      cmd_ready_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      state       <= state_nx;
      beat        <= beat_nx;
      cnt         <= cnt_nx;
      rd_shift    <= rd_shift_nx;
      rsp_dat_o   <= rsp_nx;
      gsel_b_o    <= gsel_nx;
      grdwr_b_o   <= grdwr_nx;
      gad_oe_o    <= oe_nx;
      gad_o       <= gad_nx;
      cmd_ready_o <= ready_nx;
      done_o      <= done_nx;
      if (state == ST_IDLE && accept) begin
        lat_wr   <= cmd_wr_i;
        lat_addr <= cmd_addr_i;
        lat_dat  <= cmd_dat_i;
      end
    end
  end

`ifdef GLITCBUS_MASTER_DEBUG_EN
  // The listed fields exceed 71 bits, so GAD out/in share one byte field:
  // whichever direction is currently driving the pins is recorded.
  logic [2:0] dbg_cnt;
  logic [7:0] dbg_gad;
  assign dbg_cnt = (state == ST_TURN || state == ST_GAP) ? cnt : {1'b0, beat};
  assign dbg_gad = gad_oe_o ? gad_o : gad_i;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      debug_o <= 71'h0;
    end else begin
      debug_o <= {state, dbg_cnt, gsel_b_o, grdwr_b_o, gad_oe_o, dbg_gad,
                  lat_addr, rsp_dat_o, done_o, 5'b00000};
    end
  end
`endif

endmodule
`default_nettype wire
